// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial front end.
package serializer_pkg;

  typedef enum bit {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // Width of the bit counter. It only has to reach width-1, so $clog2 is enough.
  // A floor of one bit keeps the counter a real vector.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register. It parks the next word while the current word shifts out.
module ser_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             take_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  // Capture a word on load. The full flag drops when the shifter takes the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q <= data_i;
        full_q <= 1'b1;
      end else if (take_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end. It takes WIDTH-bit words over valid/ready and
// shifts them out one bit per clock. A one-word buffer lets words stream gap-free.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             accept;
  logic             last_bit;
  logic             hold_load;
  logic             hold_take;
  logic [WIDTH-1:0] shifted;

  // Ready depends only on registered state plus reset, so there is no path from din_valid.
  assign din_ready = !rst && !hold_full;
  assign accept    = din_valid && din_ready;
  assign last_bit  = (state_q == SER_SHIFT) && (cnt_q == LAST_CNT);

  // Words arriving mid-word are parked. On the last bit they bypass straight into the shifter.
  assign hold_load = accept && (state_q == SER_SHIFT) && !last_bit;
  assign hold_take = last_bit && hold_full;

  // The head bit always sits at the output end, so shifting moves the next bit into place.
  assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  ser_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .load_i(hold_load),
    .take_i(hold_take),
    .data_i(din),
    .data_o(hold_data),
    .full_o(hold_full)
  );

  // Next-state logic: load from idle, shift mid-word, and at the last bit reload from the buffer or bypass, else go idle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      SER_IDLE: begin
        if (accept) begin
          shift_d = din;
          cnt_d   = '0;
          state_d = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (!last_bit) begin
          shift_d = shifted;
          cnt_d   = cnt_q + CW'(1);
        end else if (hold_full) begin
          shift_d = hold_data;
          cnt_d   = '0;
        end else if (accept) begin
          shift_d = din;
          cnt_d   = '0;
        end else begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = SER_IDLE;
        end
      end
    endcase
  end

  // State registers. Reset aborts any word in flight at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SER_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded from registers only, so the downstream detector sees no glitches.
  assign sout_valid = (state_q == SER_SHIFT);
  assign sout       = sout_valid && (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
  assign word_done  = last_bit;
  assign busy       = (state_q == SER_SHIFT) || hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: table vectors on both bit orders,
// directed streaming/bypass/reset sequences, a chained 110 detector, and
// randomized traffic against a queue-based model of the serial stream.
module tb_bit_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] dinM, dinL;
  logic         validM, validL;
  logic         readyM, soutM, svM, doneM, busyM;
  logic         readyL, soutL, svL, doneL, busyL;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutM (
    .clk(clk), .rst(rst), .din(dinM), .din_valid(validM), .din_ready(readyM),
    .sout(soutM), .sout_valid(svM), .word_done(doneM), .busy(busyM)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutL (
    .clk(clk), .rst(rst), .din(dinL), .din_valid(validL), .din_ready(readyL),
    .sout(soutL), .sout_valid(svL), .word_done(doneL), .busy(busyL)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the MSB-first unit. It keeps a queue of bits still owed on sout.
  // Each bit carries a flag for the last bit of its word. From the queue length:
  // valid and busy mean non-empty, and a held word exists once more than W bits are owed.
  typedef struct packed {
    logic b;
    logic last;
  } owed_t;

  owed_t owedQ[$];
  logic  modelAcc = 1'b0;
  int    owedSz;

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rstReadyM", readyM, 0);
      checkOutput("rstValidM", svM, 0);
      checkOutput("rstSoutM", soutM, 0);
      checkOutput("rstDoneM", doneM, 0);
      checkOutput("rstBusyM", busyM, 0);
      owedQ.delete();
      modelAcc = 1'b0;
    end else begin
      owedSz = owedQ.size();
      checkOutput("mdlReady", readyM, (owedSz <= W));
      checkOutput("mdlBusy", busyM, (owedSz > 0));
      checkOutput("mdlValid", svM, (owedSz > 0));
      if (owedSz > 0) begin
        checkOutput("mdlSout", soutM, owedQ[0].b);
        checkOutput("mdlDone", doneM, owedQ[0].last);
        void'(owedQ.pop_front());
      end else begin
        checkOutput("mdlSoutIdle", soutM, 0);
        checkOutput("mdlDoneIdle", doneM, 0);
      end
      modelAcc = validM && (owedSz <= W);
      if (modelAcc) begin
        for (int i = W - 1; i >= 0; i--) owedQ.push_back('{b: dinM[i], last: (i == 0)});
      end
    end
  end

  // Stand-in 110 detector chained on the MSB-first serial output.
  logic [2:0] detHist;
  int         detCount;
  always @(negedge clk) begin
    if (rst) begin
      detHist  = 3'b000;
      detCount = 0;
    end else if (svM) begin
      detHist = {detHist[1:0], soutM};
      if (detHist == 3'b110) detCount++;
    end
  end

  // Offer a word to the MSB-first unit. Return the number of cycles it waited (1 = accepted at once).
  task automatic offerM(input logic [W-1:0] w, output int waited);
    waited = 0;
    dinM   = w;
    validM = 1'b1;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (!modelAcc && waited < 200);
    if (!modelAcc) begin
      checks++;
      errors++;
      $display("[TB] FAIL offerTimeout: word %0h not accepted in %0d cycles", w, waited);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         lsb;
    logic [7:0] din;
    logic [7:0] expSeq;
  } vec_t;

  vec_t vecs[7];

  // Send one word to the selected unit from idle. Collect its eight serial bits in send order (first bit in bit 7).
  task automatic applyStimulus(input vec_t v);
    logic [7:0] seq, dn, vl;
    @(posedge clk);
    #1;
    if (v.lsb) begin dinL = v.din; validL = 1'b1; end
    else       begin dinM = v.din; validM = 1'b1; end
    @(negedge clk);
    checkOutput("tblReady", v.lsb ? readyL : readyM, 1);
    @(posedge clk);
    #1;
    validL = 1'b0;
    validM = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      seq[W-1-i] = v.lsb ? soutL : soutM;
      dn[W-1-i]  = v.lsb ? doneL : doneM;
      vl[W-1-i]  = v.lsb ? svL : svM;
    end
    @(negedge clk);
    checkOutput("tblSeq", seq, v.expSeq);
    checkOutput("tblDone", dn, 8'h01);
    checkOutput("tblValid", vl, 8'hFF);
    checkOutput("tblIdleValid", v.lsb ? svL : svM, 0);
    checkOutput("tblIdleBusy", v.lsb ? busyL : busyM, 0);
  endtask

  int         n;
  int         rw;
  int         refCount;
  logic [7:0] detWord;

  initial begin
    vecs[0] = '{lsb: 1'b0, din: 8'hC3, expSeq: 8'hC3};
    vecs[1] = '{lsb: 1'b1, din: 8'h06, expSeq: 8'h60};
    vecs[2] = '{lsb: 1'b0, din: 8'h6C, expSeq: 8'h6C};
    vecs[3] = '{lsb: 1'b1, din: 8'hC3, expSeq: 8'hC3};
    vecs[4] = '{lsb: 1'b1, din: 8'h01, expSeq: 8'h80};
    vecs[5] = '{lsb: 1'b0, din: 8'h81, expSeq: 8'h81};
    vecs[6] = '{lsb: 1'b1, din: 8'h1E, expSeq: 8'h78};

    rst = 1'b0; validM = 1'b0; validL = 1'b0; dinM = '0; dinL = '0;
    #1 rst = 1'b1;
    #12;
    checkOutput("resetReadyL", readyL, 0);
    checkOutput("resetBusyL", busyL, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    for (int v = 0; v < 7; v++) applyStimulus(vecs[v]);

    // Back-to-back stream with valid held high. The third word must wait for the buffer to drain.
    @(posedge clk); #1;
    offerM(8'hC3, n);
    checkOutput("b2bFirstWait", n, 1);
    offerM(8'h6C, n);
    checkOutput("b2bSecondWait", n, 1);
    offerM(8'h5A, n);
    checkOutput("b2bThirdWait", n, 8);
    validM = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    // Bypass case: the next word arrives exactly during the last bit of a lone word.
    offerM(8'hC3, n);
    validM = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    offerM(8'h6C, n);
    checkOutput("bypassWait", n, 1);
    validM = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Reset mid-word at bit 4 of FF with AA parked in the buffer.
    offerM(8'hFF, n);
    offerM(8'hAA, n);
    checkOutput("rstHoldWait", n, 1);
    validM = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("preRstBusy", busyM, 1);
    rst = 1'b1;
    #1;
    checkOutput("midRstValid", svM, 0);
    checkOutput("midRstSout", soutM, 0);
    checkOutput("midRstDone", doneM, 0);
    checkOutput("midRstBusy", busyM, 0);
    checkOutput("midRstReady", readyM, 0);
    checkOutput("midRstReadyL", readyL, 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("postRstReady", readyM, 1);
    checkOutput("postRstBusy", busyM, 0);

    // A clean word after reset also drives the chained 110 detector.
    @(posedge clk); #1;
    detWord = 8'h6C;
    offerM(detWord, n);
    validM = 1'b0;
    repeat (12) @(negedge clk);
    refCount = 0;
    for (int i = 0; i + 2 < W; i++) begin
      if (detWord[W-1-i] == 1'b1 && detWord[W-2-i] == 1'b1 && detWord[W-3-i] == 1'b0) refCount++;
    end
    checkOutput("detPulses", detCount, refCount);

    // Randomized traffic with random idle gaps.
    @(posedge clk); #1;
    for (int k = 0; k < 60; k++) begin
      rw = $urandom;
      offerM(rw[W-1:0], n);
      if ($urandom_range(0, 2) == 0) begin
        validM = 1'b0;
        repeat ($urandom_range(0, 12)) @(posedge clk);
        #1;
      end
    end
    validM = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("finalBusy", busyM, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
